cpu_trace_serializer: RTL

- Upstream producer for the trace-line checker.
- Takes one parallel CPU write record per handshake and emits it as an ASCII character stream, one character per clock.
- Line formats:
  - Memory write: "^<time>@<pc>: *<addr> <= <data>#"
  - Register write: "^<time>@<pc>: $<grf> <= <data>#"
- Its `char` output connects directly to the checker's `char` input, so the checker is driven by generated traffic instead of hand-typed stimulus.

---
 rtl/cpu_trace_serializer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/cpu_trace_serializer.sv
// Serializes one CPU write record per handshake into an ASCII trace line, one character per clock.
// '^' appears the cycle after the accept edge. in_ready is high only in IDLE, so a record is never accepted mid-line.
`timescale 1ns/1ps

module cpu_trace_serializer #(
  parameter bit HEX_UPPER = 1'b0,
  parameter int GAP       = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_kind,
  input  logic [15:0] in_time,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_addr,
  input  logic [4:0]  in_grf,
  input  logic [31:0] in_data,
  output logic [7:0]  char,
  output logic        busy,
  output logic        last
);

  typedef enum logic [3:0] {
    S_IDLE, S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_SP1, S_MARK,
    S_OPND, S_SP2, S_LT, S_EQ, S_SP3, S_DATA, S_HASH, S_GAPWAIT
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] gap_q, gap_d;
  logic [7:0]  char_q, char_d;
  logic        busy_q, busy_d;
  logic        last_q, last_d;

  logic        kind_q;
  logic [31:0] pc_q, addr_q, data_q;
  logic [15:0] t_bcd_q, t_bcd_d;
  logic [1:0]  td_q, td_d;
  logic [7:0]  g_bcd_q, g_bcd_d;
  logic        rd_q, rd_d;

  logic        accept;
  logic [13:0] t_sat, t_q1, t_q2;

  assign in_ready = (state_q == S_IDLE) && !reset;
  assign accept   = in_valid && in_ready;
  assign char     = char_q;
  assign busy     = busy_q;
  assign last     = last_q;

  // Decimal fields are split into BCD at accept; td/rd hold digit count minus one.
  always_comb begin
    t_sat   = (in_time > 16'd9999) ? 14'd9999 : in_time[13:0];
    t_q1    = t_sat / 14'd10;
    t_q2    = t_q1 / 14'd10;
    t_bcd_d = {4'(t_q2 / 14'd10), 4'(t_q2 % 14'd10), 4'(t_q1 % 14'd10), 4'(t_sat % 14'd10)};
    if (t_sat >= 14'd1000)     td_d = 2'd3;
    else if (t_sat >= 14'd100) td_d = 2'd2;
    else if (t_sat >= 14'd10)  td_d = 2'd1;
    else                       td_d = 2'd0;
    g_bcd_d = {4'(in_grf / 5'd10), 4'(in_grf % 5'd10)};
    rd_d    = (in_grf >= 5'd10);
  end

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (HEX_UPPER ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  function automatic logic [3:0] nib(input logic [31:0] v, input logic [2:0] idx);
    return v[{3'd7 - idx, 2'b00} +: 4];
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_CARET;
      S_CARET: begin state_d = S_TIME; cnt_d = 3'd0; end
      S_TIME:
        if (cnt_q[1:0] == td_q) begin state_d = S_AT; cnt_d = 3'd0; end
        else cnt_d = cnt_q + 3'd1;
      S_AT:    begin state_d = S_PC; cnt_d = 3'd0; end
      S_PC:
        if (cnt_q == 3'd7) state_d = S_COLON;
        else cnt_d = cnt_q + 3'd1;
      S_COLON: state_d = S_SP1;
      S_SP1:   state_d = S_MARK;
      S_MARK:  begin state_d = S_OPND; cnt_d = 3'd0; end
      S_OPND:
        if (kind_q ? (cnt_q == 3'd7) : (cnt_q == {2'b00, rd_q})) state_d = S_SP2;
        else cnt_d = cnt_q + 3'd1;
      S_SP2:   state_d = S_LT;
      S_LT:    state_d = S_EQ;
      S_EQ:    state_d = S_SP3;
      S_SP3:   begin state_d = S_DATA; cnt_d = 3'd0; end
      S_DATA:
        if (cnt_q == 3'd7) state_d = S_HASH;
        else cnt_d = cnt_q + 3'd1;
      S_HASH:
        if (GAP > 0) begin state_d = S_GAPWAIT; gap_d = 16'd0; end
        else state_d = S_IDLE;
      S_GAPWAIT:
        if (gap_q == 16'(GAP - 1)) state_d = S_IDLE;
        else gap_d = gap_q + 16'd1;
      default: state_d = S_IDLE;
    endcase
  end

  // Output character is derived from the next state so char/busy/last come straight from flops.
  always_comb begin
    char_d = 8'h00;
    case (state_d)
      S_CARET: char_d = 8'h5E;
      S_TIME:  char_d = 8'h30 + {4'h0, t_bcd_q[{td_q - cnt_d[1:0], 2'b00} +: 4]};
      S_AT:    char_d = 8'h40;
      S_PC:    char_d = hex_char(nib(pc_q, cnt_d));
      S_COLON: char_d = 8'h3A;
      S_SP1, S_SP2, S_SP3: char_d = 8'h20;
      S_MARK:  char_d = kind_q ? 8'h2A : 8'h24;
      S_OPND:
        if (kind_q) char_d = hex_char(nib(addr_q, cnt_d));
        else        char_d = 8'h30 + {4'h0, g_bcd_q[{rd_q - cnt_d[0], 2'b00} +: 4]};
      S_LT:    char_d = 8'h3C;
      S_EQ:    char_d = 8'h3D;
      S_DATA:  char_d = hex_char(nib(data_q, cnt_d));
      S_HASH:  char_d = 8'h23;
      default: char_d = 8'h00;
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_GAPWAIT);
    last_d = (state_d == S_HASH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      gap_q   <= 16'd0;
      char_q  <= 8'h00;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
      kind_q  <= 1'b0;
      pc_q    <= 32'd0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      t_bcd_q <= 16'd0;
      td_q    <= 2'd0;
      g_bcd_q <= 8'd0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      char_q  <= char_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      if (accept) begin
        kind_q  <= in_kind;
        pc_q    <= in_pc;
        addr_q  <= in_addr;
        data_q  <= in_data;
        t_bcd_q <= t_bcd_d;
        td_q    <= td_d;
        g_bcd_q <= g_bcd_d;
        rd_q    <= rd_d;
      end
    end
  end

endmodule
